// File: rtl/mem_access_stage.sv
`timescale 1ns/1ps
// mem_access_stage: memory stage between EX_MEM and write-back.
// Issues data-memory loads/stores over a req/ack handshake, stalls upstream
// while an access is outstanding, aborts after TIMEOUT unacknowledged cycles,
// and drives the MEM/WB pipeline register.
// Ports:
//   clk_i, rst_i (async, active-low)
//   control_i/ALUResult_i/RSdata2_i/RDaddr_i : EX_MEM payload
//   stall_o                                  : combinational upstream freeze
//   req_o/we_o/addr_o/wdata_o, ack_i/rdata_i : data-memory handshake
//   control_o/ALUResult_o/MemData_o/RDaddr_o : MEM/WB register
//   err_o                                    : one-cycle error pulse
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  control_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] RSdata2_i,
    input  logic [4:0]  RDaddr_i,
    output logic        stall_o,
    output logic        req_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    input  logic        ack_i,
    input  logic [31:0] rdata_i,
    output logic [1:0]  control_o,
    output logic [31:0] ALUResult_o,
    output logic [31:0] MemData_o,
    output logic [4:0]  RDaddr_o,
    output logic        err_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          req_d, we_d, err_d;
    logic [31:0]   addr_d, wdata_d, alu_d, mdata_d;
    logic [1:0]    ctrl_d;
    logic [4:0]    rd_d;
    logic          stall_c;

    // Instruction decode of the EX_MEM control bits
    logic mem_rd, mem_wr, memop, illegal, misaligned, start, cnt_at_max;

    assign mem_rd     = control_i[1];
    assign mem_wr     = control_i[0];
    assign memop      = mem_rd ^ mem_wr;
    assign illegal    = mem_rd & mem_wr;
    assign misaligned = memop & (ALUResult_i[1:0] != 2'b00);
    assign start      = memop & ~misaligned;
    assign cnt_at_max = (cnt_q == CW'(TIMEOUT));

    // Stall is forced low during reset so upstream is released immediately
    assign stall_o = rst_i & stall_c;

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_o;
        we_d    = we_o;
        addr_d  = addr_o;
        wdata_d = wdata_o;
        ctrl_d  = 2'b00;
        alu_d   = 32'h0;
        mdata_d = 32'h0;
        rd_d    = 5'h0;
        err_d   = 1'b0;
        stall_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Launch the access; MEM/WB takes a bubble meanwhile
                    stall_c = 1'b1;
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = mem_wr;
                    addr_d  = ALUResult_i;
                    wdata_d = RSdata2_i;
                    cnt_d   = '0;
                end else begin
                    // Pass-through; bad memory ops retire without writing back
                    ctrl_d = {control_i[3] & ~(illegal | misaligned), control_i[2]};
                    alu_d  = ALUResult_i;
                    rd_d   = RDaddr_i;
                    err_d  = illegal | misaligned;
                end
            end
            BUSY: begin
                if (ack_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    ctrl_d  = control_i[3:2];
                    alu_d   = ALUResult_i;
                    rd_d    = RDaddr_i;
                    mdata_d = we_o ? 32'h0 : rdata_i;
                end else if (!cnt_at_max) begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CW'(1);
                end else begin
                    // Abort: retire with RegWrite cleared and flag the error
                    state_d = IDLE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    ctrl_d  = {1'b0, control_i[2]};
                    alu_d   = ALUResult_i;
                    rd_d    = RDaddr_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, handshake and MEM/WB registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_o       <= 1'b0;
            we_o        <= 1'b0;
            addr_o      <= 32'h0;
            wdata_o     <= 32'h0;
            control_o   <= 2'b00;
            ALUResult_o <= 32'h0;
            MemData_o   <= 32'h0;
            RDaddr_o    <= 5'h0;
            err_o       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_o       <= req_d;
            we_o        <= we_d;
            addr_o      <= addr_d;
            wdata_o     <= wdata_d;
            control_o   <= ctrl_d;
            ALUResult_o <= alu_d;
            MemData_o   <= mdata_d;
            RDaddr_o    <= rd_d;
            err_o       <= err_d;
        end
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-stage consumer of the EX/MEM pipeline register: takes the latched EX results, performs the data-memory load/store over a req/ack handshake to the data memory, stalls the upstream pipeline while an access is outstanding, and drives the MEM/WB pipeline register it contains. Sits between EX_MEM and the write-back mux; non-memory instructions pass through with one cycle of latency.

## Interface
- TIMEOUT, 15, max cycles req_o may stay high without ack_i before the access is aborted (≥1)
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-low reset
- control_i  in  4  from EX_MEM: [3]=RegWrite, [2]=MemtoReg, [1]=MemRead, [0]=MemWrite
- ALUResult_i  in  32  from EX_MEM: address for mem ops, result otherwise
- RSdata2_i  in  32  from EX_MEM: store data
- RDaddr_i  in  5  from EX_MEM: destination register
- stall_o  out  1  combinational; 1 = freeze PC, IF_ID, ID_EX, EX_MEM
- req_o  out  1  registered memory request
- we_o  out  1  registered; 1 = store
- addr_o  out  32  registered word address (byte address, bits [1:0]=0)
- wdata_o  out  32  registered store data
- ack_i  in  1  memory completion, sampled on rising edge while req_o=1
- rdata_i  in  32  load data, valid when ack_i=1
- control_o  out  2  to WB: [1]=RegWrite, [0]=MemtoReg
- ALUResult_o  out  32  registered ALU result
- MemData_o  out  32  registered load data
- RDaddr_o  out  5  registered destination
- err_o  out  1  registered one-cycle pulse: misaligned, illegal, or timeout

## Operation
- memop = MemRead xor MemWrite; illegal = MemRead and MemWrite; misaligned = memop and ALUResult_i[1:0]≠0.
- FSM states IDLE, BUSY. Reset: IDLE, every output 0, timeout counter 0.
- IDLE, no memop (incl. illegal/misaligned): stall_o=0; next edge loads MEM/WB from inputs, MemData_o=0. Illegal or misaligned: RegWrite forced 0, no request, err_o=1 next cycle.
- IDLE, valid memop: stall_o=1; next edge → BUSY, req_o=1, we_o=MemWrite, addr_o=ALUResult_i, wdata_o=RSdata2_i, counter=0; MEM/WB loads bubble (control_o=0).
- BUSY: req_o, we_o, addr_o, wdata_o held. stall_o = !ack_i and counter<TIMEOUT.
  - ack_i=1: next edge → IDLE, req_o=0; MEM/WB loads control_i[3:2], ALUResult_i, RDaddr_i, MemData_o=rdata_i for loads / 0 for stores.
  - ack_i=0, counter<TIMEOUT: counter+1, MEM/WB loads bubble.
  - ack_i=0, counter=TIMEOUT: abort; next edge → IDLE, req_o=0, err_o=1, instruction retires with RegWrite=0, MemData_o=0.
- Counter width $clog2(TIMEOUT+1); never wraps.
- EX_MEM inputs are stable whenever stall_o=1 (upstream guarantee); block does not re-latch them.
- ack_i while req_o=0 ignored.

## Timing
- Non-memop latency: 1 cycle, no stall.
- Memop: req_o rises 1 cycle after instruction appears; ack on the Nth req_o cycle (N=1 = same cycle as first req_o) → stall_o high for N cycles total (1 in IDLE + N−1 in BUSY), result on MEM/WB outputs the edge after ack.
- Back-to-back memops: IDLE re-entered in the ack cycle's following edge; next memop starts immediately, req_o low for exactly 1 cycle between accesses.
- err_o high exactly one cycle per event.
- rst_i low at any time (incl. BUSY): immediate IDLE, req_o=0, all outputs 0; in-flight access abandoned, memory must tolerate a dropped request.

## Test plan
- Reset: rst_i=0 mid-BUSY with req_o=1 → req_o, stall_o, control_o, err_o all 0 immediately; after release, ADD (control_i=4'b1000, ALUResult_i=32'h5, RDaddr_i=3) → next cycle control_o=2'b10, ALUResult_o=5, RDaddr_o=3, stall_o never 1.
- Load, ack on 3rd req_o cycle: control_i=4'b1110, addr 32'h40, rdata_i=32'hDEADBEEF → stall_o high 3 cycles, req_o high 3 cycles, we_o=0, addr_o=32'h40; then control_o=2'b11, MemData_o=32'hDEADBEEF.
- Store, ack on 1st req_o cycle: control_i=4'b0001, addr 32'h80, RSdata2_i=32'h1234 → stall_o high 1 cycle, we_o=1, wdata_o=32'h1234; then control_o=2'b00, MemData_o=0.
- Misaligned load addr 32'h42 and illegal control_i=4'b1011 → no req_o, stall_o=0, err_o pulses 1 cycle each, control_o[1]=0.
- Timeout, TIMEOUT=15, ack_i stuck 0 → req_o high 16 cycles, stall_o drops after 16th cycle, err_o pulses once, control_o[1]=0, next instruction proceeds.
- Back-to-back load then store, ack after 2 cycles each → req_o low exactly 1 cycle between, both results retire in order, bubbles between.
